fifo_dest: RTL and testbench

Per-destination output FIFO placed directly downstream of the 1-to-2 destination demux; one instance each on outdest0 and outdest1. Buffers routed 8-bit words until the destination consumer pops them. Provides full/empty and programmable almost-full/almost-empty flags so upstream flow control can stall routing before overflow. Overflow and underflow are reported on a sticky error flag.

---
 rtl/fifo_dest.sv | 163 ++++++++++++++++
 tb/tb_fifo_dest.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_dest.sv
// ----------------------------------------------------------------------------
// fifo_dest
//
// Per-destination output FIFO sitting directly behind the 1-to-2 destination
// demux (one instance per output lane). Routed words are buffered here until
// the destination consumer pops them. Fill-level flags let upstream flow
// control stall routing before the buffer overflows, and a sticky error flag
// records any overflow (push while full without a pop) or underflow (pop
// while empty).
//
// Optional feature:
//   FIFO_DEST_OCC_EN - when defined, adds the 'occupancy' output carrying the
//                      registered fill count so an arbiter can see the exact
//                      fill level. When undefined, the port is absent and
//                      everything else behaves identically.
//
// Parameters:
//   DATA_WIDTH  width of each stored word
//   ADDR_WIDTH  pointer width; DEPTH = 2**ADDR_WIDTH entries
//   AF_THRESH   almost_full  asserted when count >= AF_THRESH
//   AE_THRESH   almost_empty asserted when count <= AE_THRESH
//
// Ports:
//   clk           in   single clock, all state updates on the rising edge
//   reset_L       in   asynchronous active-low reset
//   push          in   write request
//   data_in       in   word from the demux output
//   pop           in   read request from the destination consumer
//   data_out      out  registered read data (1-cycle read latency)
//   valid_out     out  data_out holds a newly popped word this cycle
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AF_THRESH
//   almost_empty  out  count <= AE_THRESH
//   error         out  sticky overflow/underflow indicator
//   occupancy     out  registered count (only with FIFO_DEST_OCC_EN)
// ----------------------------------------------------------------------------
module fifo_dest #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int AF_THRESH  = 3,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
`ifdef FIFO_DEST_OCC_EN
    ,
    output logic [ADDR_WIDTH:0]   occupancy
`else
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Count-width versions of the constants so every flag compare is
    // between equal-width operands.
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;

    logic pop_ok;
    logic push_ok;
    logic overflow;
    logic underflow;

    // Flags decode the registered count only, so they move one cycle after
    // the push/pop that caused them and there is no input-to-output path.
    assign full         = (count == DEPTH_CNT);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_CNT);
    assign almost_empty = (count <= AE_CNT);

`ifdef FIFO_DEST_OCC_EN
    assign occupancy = count;
`else
`endif

    // A pop is honoured whenever something is stored. A push is honoured
    // when there is room, or when a same-cycle pop frees the slot it needs,
    // which lets a full FIFO stream at full rate.
    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        overflow  = push && !push_ok;
        underflow = pop && empty;
    end

    // Storage array: no reset needed since contents are only ever read
    // after being written, and the pointers/count are reset instead.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Fill count: a simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered read port: data_out keeps the last popped word when no pop
    // is accepted, while valid_out marks only freshly popped cycles.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
            end
        end
    end

    // Sticky error: set on a dropped push or an ignored pop, cleared only
    // by reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error <= 1'b0;
        end else if (overflow || underflow) begin
            error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_dest.sv
// ----------------------------------------------------------------------------
// tb_fifo_dest
//
// Directed self-checking bench for fifo_dest with default parameters
// (8-bit words, depth 4, almost_full at >=3, almost_empty at <=1).
// Flags are compared as one vector {full, almost_full, almost_empty, empty,
// error}.
// ----------------------------------------------------------------------------
module tb_fifo_dest;

    logic       clk;
    logic       reset_L;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic [7:0] data_out;
    logic       valid_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
`ifdef FIFO_DEST_OCC_EN
    logic [2:0] occupancy;
`else
`endif

    int total;
    int bad;

    logic [4:0] flags;
    assign flags = {full, almost_full, almost_empty, empty, error};

    fifo_dest #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(2),
        .AF_THRESH (3),
        .AE_THRESH (1)
    ) dut (
        .clk         (clk),
        .reset_L     (reset_L),
        .push        (push),
        .data_in     (data_in),
        .pop         (pop),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .error       (error)
`ifdef FIFO_DEST_OCC_EN
        ,
        .occupancy   (occupancy)
`else
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, let the rising edge take it, then sample
    // 1 time unit after the edge with inputs returned to idle.
    task automatic step(input logic p, input logic [7:0] d, input logic q);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    // Short reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        reset_L = 1'b0;
        #2;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        // Make outputs non-reset first: a word popped and an underflow.
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h6B, 1'b0);
        total++;
        if ({data_out, valid_out, flags} !== {8'h5A, 1'b0, 5'b00101}) begin
            bad++;
            $display("[TB] FAIL pre_reset got=%h exp=%h",
                     {data_out, valid_out, flags}, {8'h5A, 1'b0, 5'b00101});
        end
        #2;
        reset_L = 1'b0;
        #1;
        total++;
        if ({data_out, valid_out, flags} !== {8'h00, 1'b0, 5'b00110}) begin
            bad++;
            $display("[TB] FAIL async_reset got=%h exp=%h",
                     {data_out, valid_out, flags}, {8'h00, 1'b0, 5'b00110});
        end
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] words [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        logic [4:0] expf  [4] = '{5'b00100, 5'b00000, 5'b01000, 5'b11000};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, words[i], 1'b0);
            total++;
            if (flags !== expf[i]) begin
                bad++;
                $display("[TB] FAIL fill_flags[%0d] got=%b exp=%b", i, flags, expf[i]);
            end
        end
        step(1'b1, 8'h55, 1'b0);
        total++;
        if (flags !== 5'b11001) begin
            bad++;
            $display("[TB] FAIL overflow_flags got=%b exp=%b", flags, 5'b11001);
        end
    endtask

    task automatic test_drain();
        logic [7:0] words [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        logic [4:0] expf  [4] = '{5'b01001, 5'b00001, 5'b00101, 5'b00111};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++;
            if ({valid_out, data_out, flags} !== {1'b1, words[i], expf[i]}) begin
                bad++;
                $display("[TB] FAIL drain[%0d] got=%h exp=%h", i,
                         {valid_out, data_out, flags}, {1'b1, words[i], expf[i]});
            end
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({valid_out, data_out, flags} !== {1'b0, 8'hA4, 5'b00111}) begin
            bad++;
            $display("[TB] FAIL underflow got=%h exp=%h",
                     {valid_out, data_out, flags}, {1'b0, 8'hA4, 5'b00111});
        end
    endtask

    task automatic test_simul_full();
        logic [7:0] rest [4] = '{8'hB2, 8'hB3, 8'hB4, 8'h77};
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hB1 + 8'(i), 1'b0);
        end
        step(1'b1, 8'h77, 1'b1);
        total++;
        if ({valid_out, data_out, flags} !== {1'b1, 8'hB1, 5'b11000}) begin
            bad++;
            $display("[TB] FAIL simul_full got=%h exp=%h",
                     {valid_out, data_out, flags}, {1'b1, 8'hB1, 5'b11000});
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            total++;
            if ({valid_out, data_out} !== {1'b1, rest[i]}) begin
                bad++;
                $display("[TB] FAIL simul_pop[%0d] got=%h exp=%h", i,
                         {valid_out, data_out}, {1'b1, rest[i]});
            end
        end
        total++;
        if (flags !== 5'b00110) begin
            bad++;
            $display("[TB] FAIL simul_end got=%b exp=%b", flags, 5'b00110);
        end
    endtask

    task automatic test_wrap();
        pulse_reset();
        step(1'b1, 8'h10, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            logic [7:0] expd;
            expd = 8'h10 + 8'(i - 1);
            if (i < 10) step(1'b1, 8'h10 + 8'(i), 1'b1);
            else        step(1'b0, 8'h00, 1'b1);
            total++;
            if ({valid_out, data_out} !== {1'b1, expd}) begin
                bad++;
                $display("[TB] FAIL wrap[%0d] got=%h exp=%h", i,
                         {valid_out, data_out}, {1'b1, expd});
            end
        end
        total++;
        if (flags !== 5'b00110) begin
            bad++;
            $display("[TB] FAIL wrap_end got=%b exp=%b", flags, 5'b00110);
        end
    endtask

    task automatic test_pop_empty_push();
        pulse_reset();
        step(1'b1, 8'h66, 1'b1);
        total++;
        if ({valid_out, flags} !== {1'b0, 5'b00101}) begin
            bad++;
            $display("[TB] FAIL pop_empty_push got=%b exp=%b",
                     {valid_out, flags}, {1'b0, 5'b00101});
        end
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({valid_out, data_out} !== {1'b1, 8'h66}) begin
            bad++;
            $display("[TB] FAIL pop_empty_read got=%h exp=%h",
                     {valid_out, data_out}, {1'b1, 8'h66});
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hC0 + 8'(i), 1'b0);
        end
        total++;
        if (flags !== 5'b01000) begin
            bad++;
            $display("[TB] FAIL mid_pre got=%b exp=%b", flags, 5'b01000);
        end
        #2;
        reset_L = 1'b0;
        #1;
        total++;
        if (flags !== 5'b00110) begin
            bad++;
            $display("[TB] FAIL mid_reset got=%b exp=%b", flags, 5'b00110);
        end
        #1;
        reset_L = 1'b1;
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        total++;
        if ({valid_out, data_out, flags} !== {1'b1, 8'h3C, 5'b00110}) begin
            bad++;
            $display("[TB] FAIL mid_after got=%h exp=%h",
                     {valid_out, data_out, flags}, {1'b1, 8'h3C, 5'b00110});
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_L = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        #12;
        reset_L = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_simul_full();
        test_wrap();
        test_pop_empty_push();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
